// File: rtl/eu_pipe.sv
// ---------------------------------------------------------------------------
// eu_pipe -- handshaked execution unit with multi-cycle multiply, result
// forwarding and zero/carry flags.
//
// Accepts one instruction at a time. The result lives in a single output
// register that is held until the consumer takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload
// steady until that edge. in_ready may depend combinationally on out_ready
// and reset. out_valid is purely registered state.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   in_valid / in_ready        instruction handshake
//   opcode, opAAdr, opBAdr,    instruction fields from control and
//   dest_reg, storeDataAdr,    register read
//   operandA, operandB
//   out_valid / out_ready      result handshake
//   result, write_enable,      register write-back
//   destReg
//   store_data,                data-memory write
//   storeDataAdrOut,
//   data_memory_write_enable
//   flag_z, flag_c             zero / carry of the last ALU operation
//   dbg_state                  current FSM state (IDLE/BUSY/FULL)
// ---------------------------------------------------------------------------
module eu_pipe #(
  parameter int DATA_W     = 8,
  parameter int REG_ADR_W  = 3,
  parameter int MEM_ADR_W  = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [REG_ADR_W-1:0] opAAdr,
  input  logic [REG_ADR_W-1:0] opBAdr,
  input  logic [REG_ADR_W-1:0] dest_reg,
  input  logic [MEM_ADR_W-1:0] storeDataAdr,
  input  logic [DATA_W-1:0]    operandA,
  input  logic [DATA_W-1:0]    operandB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    result,
  output logic                 write_enable,
  output logic [REG_ADR_W-1:0] destReg,
  output logic [DATA_W-1:0]    store_data,
  output logic [MEM_ADR_W-1:0] storeDataAdrOut,
  output logic                 data_memory_write_enable,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

  // FSM and multiply state
  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    mul_a;
  logic [DATA_W-1:0]    mul_b;
  logic [REG_ADR_W-1:0] mul_dest;

  // Forwarding record: last completed register-writing ALU op
  logic                 fwd_valid;
  logic [REG_ADR_W-1:0] fwd_dest;
  logic [DATA_W-1:0]    fwd_data;

  // Output register
  logic [DATA_W-1:0]    res_q;
  logic                 we_q;
  logic [REG_ADR_W-1:0] dest_q;
  logic [DATA_W-1:0]    sd_q;
  logic [MEM_ADR_W-1:0] sda_q;
  logic                 dmwe_q;
  logic                 fz_q;
  logic                 fc_q;

  // Combinational helpers
  logic                 accept;
  logic                 is_alu;
  logic                 is_mul;
  logic [DATA_W-1:0]    a_fwd;
  logic [DATA_W-1:0]    b_fwd;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_c;
  logic [2*DATA_W-1:0]  mul_prod;
  logic [DATA_W-1:0]    mul_lo;
  logic                 mul_c;
  logic [DATA_W-1:0]    nxt_res;
  logic                 nxt_we;
  logic [REG_ADR_W-1:0] nxt_dest;
  logic [DATA_W-1:0]    nxt_sd;
  logic [MEM_ADR_W-1:0] nxt_sda;
  logic                 nxt_dmwe;

  // in_ready is forced low while reset is asserted, even though the state
  // register already reads IDLE at that point.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: in_ready = 1'b1;
        ST_FULL: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign is_mul = (opcode == OP_MUL);
  // Opcodes 0..7 are single-cycle ALU ops; MUL is handled through BUSY.
  assign is_alu = (opcode < OP_MUL);

  // Operand forwarding from the record
  assign a_fwd = (fwd_valid && (fwd_dest == opAAdr)) ? fwd_data : operandA;
  assign b_fwd = (fwd_valid && (fwd_dest == opBAdr)) ? fwd_data : operandB;

  // Single-cycle ALU. Logic ops report carry 0.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD: {alu_c, alu_res} = {1'b0, a_fwd} + {1'b0, b_fwd};
      // The extra top bit of the subtraction is the borrow (A < B).
      OP_SUB: {alu_c, alu_res} = {1'b0, a_fwd} - {1'b0, b_fwd};
      OP_AND: alu_res = a_fwd & b_fwd;
      OP_OR:  alu_res = a_fwd | b_fwd;
      OP_XOR: alu_res = a_fwd ^ b_fwd;
      OP_NOT: alu_res = ~a_fwd;
      OP_SHL: begin
        alu_res = {a_fwd[DATA_W-2:0], 1'b0};
        alu_c   = a_fwd[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_fwd[DATA_W-1:1]};
        alu_c   = a_fwd[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Multiply on the operands latched at accept; the product is consumed
  // only on the last BUSY cycle.
  assign mul_prod = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};
  assign mul_lo   = mul_prod[DATA_W-1:0];
  assign mul_c    = |mul_prod[2*DATA_W-1:DATA_W];

  // Output fields for a non-MUL instruction being accepted this cycle
  always_comb begin
    nxt_res  = '0;
    nxt_we   = 1'b0;
    nxt_dest = dest_reg;
    nxt_sd   = '0;
    nxt_sda  = '0;
    nxt_dmwe = 1'b0;
    if (is_alu) begin
      nxt_res = alu_res;
      nxt_we  = 1'b1;
    end else if (opcode == OP_LOAD) begin
      nxt_we   = 1'b1;
      nxt_dest = opAAdr;
      nxt_sda  = storeDataAdr;
    end else if (opcode == OP_STORE) begin
      nxt_dmwe = 1'b1;
      nxt_sd   = a_fwd;
      nxt_sda  = storeDataAdr;
      nxt_dest = opAAdr;
    end
  end

  // Accepts only occur in IDLE or in FULL with out_ready (in_ready encodes
  // that), so the accept branch is checked first for both states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_dest  <= '0;
      fwd_valid <= 1'b0;
      fwd_dest  <= '0;
      fwd_data  <= '0;
      res_q     <= '0;
      we_q      <= 1'b0;
      dest_q    <= '0;
      sd_q      <= '0;
      sda_q     <= '0;
      dmwe_q    <= 1'b0;
      fz_q      <= 1'b0;
      fc_q      <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        state    <= ST_BUSY;
        mul_a    <= a_fwd;
        mul_b    <= b_fwd;
        mul_dest <= dest_reg;
        cnt      <= CNT_INIT;
      end else begin
        state  <= ST_FULL;
        res_q  <= nxt_res;
        we_q   <= nxt_we;
        dest_q <= nxt_dest;
        sd_q   <= nxt_sd;
        sda_q  <= nxt_sda;
        dmwe_q <= nxt_dmwe;
        if (is_alu) begin
          fz_q      <= (alu_res == '0);
          fc_q      <= alu_c;
          fwd_valid <= 1'b1;
          fwd_dest  <= dest_reg;
          fwd_data  <= alu_res;
        end else if (opcode == OP_LOAD) begin
          fwd_valid <= 1'b0;
        end
      end
    end else begin
      case (state)
        ST_BUSY: begin
          if (cnt == '0) begin
            state     <= ST_FULL;
            res_q     <= mul_lo;
            we_q      <= 1'b1;
            dest_q    <= mul_dest;
            sd_q      <= '0;
            sda_q     <= '0;
            dmwe_q    <= 1'b0;
            fz_q      <= (mul_lo == '0);
            fc_q      <= mul_c;
            fwd_valid <= 1'b1;
            fwd_dest  <= mul_dest;
            fwd_data  <= mul_lo;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= state;
      endcase
    end
  end

  assign out_valid                = (state == ST_FULL);
  assign result                   = res_q;
  assign write_enable             = out_valid && we_q;
  assign destReg                  = dest_q;
  assign store_data               = sd_q;
  assign storeDataAdrOut          = sda_q;
  assign data_memory_write_enable = out_valid && dmwe_q;
  assign flag_z                   = fz_q;
  assign flag_c                   = fc_q;
  assign dbg_state                = state;

endmodule

// File: tb/tb_eu_pipe.sv
// ---------------------------------------------------------------------------
// tb_eu_pipe -- self-checking bench for eu_pipe (default parameters).
// Directed scenarios followed by a randomized run scored against an
// arithmetic model of the instruction set.
// ---------------------------------------------------------------------------
module tb_eu_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [2:0] opAAdr;
  logic [2:0] opBAdr;
  logic [2:0] dest_reg;
  logic [3:0] storeDataAdr;
  logic [7:0] operandA;
  logic [7:0] operandB;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       write_enable;
  logic [2:0] destReg;
  logic [7:0] store_data;
  logic [3:0] storeDataAdrOut;
  logic       data_memory_write_enable;
  logic       flag_z;
  logic       flag_c;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       we;
    logic [2:0] dest;
    logic [7:0] sd;
    logic [3:0] sda;
    logic       dmwe;
    logic       fz;
    logic       fc;
    logic       chk_res;
    logic       chk_dest;
    logic       chk_sd;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m_fv, m_fd, m_fr, m_fz, m_fc;

  eu_pipe #(.DATA_W(8), .REG_ADR_W(3), .MEM_ADR_W(4), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .opAAdr(opAAdr), .opBAdr(opBAdr), .dest_reg(dest_reg),
    .storeDataAdr(storeDataAdr), .operandA(operandA), .operandB(operandB),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .write_enable(write_enable), .destReg(destReg),
    .store_data(store_data), .storeDataAdrOut(storeDataAdrOut),
    .data_memory_write_enable(data_memory_write_enable),
    .flag_z(flag_z), .flag_c(flag_c), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Starts at a falling edge, holds the instruction until accepted and
  // returns at the falling edge after the accepting rising edge.
  task automatic drive(input logic [3:0] op, input logic [2:0] aa,
                       input logic [2:0] ba, input logic [2:0] d,
                       input logic [3:0] sa, input logic [7:0] a,
                       input logic [7:0] b);
    int w;
    opcode = op; opAAdr = aa; opBAdr = ba; dest_reg = d;
    storeDataAdr = sa; operandA = a; operandB = b;
    in_valid = 1'b1;
    w = 0;
    #1;
    while (!in_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL drive_timeout: in_ready got %0b required 1 for opcode %0d", in_ready, op);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(int op, int aa, int ba, int d, int sa, int a, int b);
    exp_t e;
    int av, bv, r, c, p;
    av = (m_fv != 0 && m_fd == aa) ? m_fr : a;
    bv = (m_fv != 0 && m_fd == ba) ? m_fr : b;
    r = 0; c = 0;
    e = '0;
    e.chk_res = 1'b1; e.chk_dest = 1'b1; e.chk_sd = 1'b1;
    if (op <= 8) begin
      case (op)
        0: begin r = av + bv; c = (r > 255) ? 1 : 0; r = r % 256; end
        1: begin c = (av < bv) ? 1 : 0; r = (av - bv + 256) % 256; end
        2: r = av & bv;
        3: r = av | bv;
        4: r = av ^ bv;
        5: r = 255 - av;
        6: begin r = (av * 2) % 256; c = (av >= 128) ? 1 : 0; end
        7: begin r = av / 2; c = av % 2; end
        default: begin p = av * bv; r = p % 256; c = (p > 255) ? 1 : 0; end
      endcase
      e.res = 8'(r); e.we = 1'b1; e.dest = 3'(d);
      m_fz = (r == 0) ? 1 : 0; m_fc = c;
      m_fv = 1; m_fd = d; m_fr = r;
    end else if (op == 14) begin
      e.we = 1'b1; e.dest = 3'(aa); e.sda = 4'(sa); e.chk_sd = 1'b0;
      m_fv = 0;
    end else if (op == 15) begin
      e.dmwe = 1'b1; e.sd = 8'(av); e.sda = 4'(sa); e.dest = 3'(aa);
      e.chk_res = 1'b0;
    end else begin
      e.chk_res = 1'b0; e.chk_dest = 1'b0;
    end
    e.fz = m_fz[0]; e.fc = m_fc[0];
    return e;
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h01;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    opcode = 4'd0; opAAdr = 3'd1; opBAdr = 3'd2; dest_reg = 3'd3;
    storeDataAdr = 4'd5; operandA = 8'h11; operandB = 8'h22;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, result, write_enable, destReg, store_data,
         storeDataAdrOut, data_memory_write_enable, flag_z, flag_c} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_state: got ov=%0b ir=%0b res=%h we=%0b dest=%0d sd=%h sda=%0d dmwe=%0b z=%0b c=%0b required all 0",
               out_valid, in_ready, result, write_enable, destReg, store_data,
               storeDataAdrOut, data_memory_write_enable, flag_z, flag_c);
    end
    in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_alu_basics();
    apply_reset();
    out_ready = 1'b1;
    drive(4'd0, 3'd4, 3'd5, 3'd2, 4'd0, 8'h7F, 8'h01);
    #1; n_cmp++;
    if ({out_valid, write_enable, destReg, result, flag_z, flag_c} !== {1'b1, 1'b1, 3'd2, 8'h80, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add_7f_01: got ov=%0b we=%0b dest=%0d res=%h z=%0b c=%0b required 1 1 2 80 0 0",
               out_valid, write_enable, destReg, result, flag_z, flag_c);
    end
    drive(4'd1, 3'd6, 3'd7, 3'd3, 4'd0, 8'h00, 8'h01);
    #1; n_cmp++;
    if ({out_valid, write_enable, destReg, result, flag_z, flag_c} !== {1'b1, 1'b1, 3'd3, 8'hFF, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_00_01: got ov=%0b we=%0b dest=%0d res=%h z=%0b c=%0b required 1 1 3 ff 0 1",
               out_valid, write_enable, destReg, result, flag_z, flag_c);
    end
    drive(4'd2, 3'd6, 3'd7, 3'd4, 4'd0, 8'hF0, 8'h0F);
    #1; n_cmp++;
    if ({out_valid, write_enable, destReg, result, flag_z, flag_c} !== {1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL and_f0_0f: got ov=%0b we=%0b dest=%0d res=%h z=%0b c=%0b required 1 1 4 00 1 0",
               out_valid, write_enable, destReg, result, flag_z, flag_c);
    end
  endtask

  task automatic test_mul_latency();
    apply_reset();
    out_ready = 1'b1;
    drive(4'd8, 3'd1, 3'd2, 3'd6, 4'd0, 8'h10, 8'h11);
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL mul_busy_cycle%0d: got in_ready=%0b out_valid=%0b required 0 0", i + 1, in_ready, out_valid);
      end
      @(negedge clk);
    end
    #1; n_cmp++;
    if ({out_valid, write_enable, destReg, result, flag_z, flag_c} !== {1'b1, 1'b1, 3'd6, 8'h10, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL mul_result: got ov=%0b we=%0b dest=%0d res=%h z=%0b c=%0b required 1 1 6 10 0 1",
               out_valid, write_enable, destReg, result, flag_z, flag_c);
    end
  endtask

  task automatic test_forwarding();
    apply_reset();
    out_ready = 1'b1;
    drive(4'd0, 3'd5, 3'd6, 3'd1, 4'd0, 8'd3, 8'd4);
    #1; n_cmp++;
    if ({out_valid, result} !== {1'b1, 8'h07}) begin
      n_bad++;
      $display("FAIL fwd_first: got ov=%0b res=%h required 1 07", out_valid, result);
    end
    drive(4'd0, 3'd1, 3'd7, 3'd3, 4'd0, 8'd0, 8'd1);
    #1; n_cmp++;
    if ({out_valid, destReg, result} !== {1'b1, 3'd3, 8'h08}) begin
      n_bad++;
      $display("FAIL fwd_second: got ov=%0b dest=%0d res=%h required 1 3 08", out_valid, destReg, result);
    end
  endtask

  task automatic test_store_backpressure();
    apply_reset();
    out_ready = 1'b0;
    drive(4'd15, 3'd4, 3'd0, 3'd0, 4'd9, 8'hA5, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if ({out_valid, in_ready, data_memory_write_enable, store_data, storeDataAdrOut, write_enable, destReg}
          !== {1'b1, 1'b0, 1'b1, 8'hA5, 4'd9, 1'b0, 3'd4}) begin
        n_bad++;
        $display("FAIL store_hold%0d: got ov=%0b ir=%0b dmwe=%0b sd=%h sda=%0d we=%0b dest=%0d required 1 0 1 a5 9 0 4",
                 i, out_valid, in_ready, data_memory_write_enable, store_data, storeDataAdrOut, write_enable, destReg);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk); #1; n_cmp++;
    if ({out_valid, data_memory_write_enable} !== 2'b00) begin
      n_bad++;
      $display("FAIL store_release: got ov=%0b dmwe=%0b required 0 0", out_valid, data_memory_write_enable);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic saw;
    apply_reset();
    out_ready = 1'b1;
    drive(4'd8, 3'd1, 3'd2, 3'd5, 4'd0, 8'h03, 8'h05);
    @(negedge clk);
    reset = 1'b1;
    #1; n_cmp++;
    if ({out_valid, in_ready, result, write_enable, destReg, store_data,
         storeDataAdrOut, data_memory_write_enable, flag_z, flag_c} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_busy: got ov=%0b ir=%0b res=%h we=%0b dest=%0d z=%0b c=%0b required all 0",
               out_valid, in_ready, result, write_enable, destReg, flag_z, flag_c);
    end
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy_emit: got out_valid seen=%0b required 0", saw);
    end
    @(negedge clk);
    drive(4'd0, 3'd1, 3'd2, 3'd5, 4'd0, 8'd1, 8'd2);
    #1; n_cmp++;
    if ({out_valid, write_enable, destReg, result} !== {1'b1, 1'b1, 3'd5, 8'h03}) begin
      n_bad++;
      $display("FAIL reset_busy_next_add: got ov=%0b we=%0b dest=%0d res=%h required 1 1 5 03",
               out_valid, write_enable, destReg, result);
    end
  endtask

  task automatic test_random();
    exp_t e, g;
    logic pending;
    apply_reset();
    m_fv = 0; m_fd = 0; m_fr = 0; m_fz = 0; m_fc = 0;
    exp_q.delete();
    pending = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (!pending) in_valid = 1'b0;
      if (cyc < 700) begin
        if (!pending && $urandom_range(0, 3) != 0) begin
          opcode = 4'($urandom_range(0, 15));
          opAAdr = 3'($urandom_range(0, 3));
          opBAdr = 3'($urandom_range(0, 3));
          dest_reg = 3'($urandom_range(0, 3));
          storeDataAdr = 4'($urandom_range(0, 15));
          operandA = pick8();
          operandB = pick8();
          in_valid = 1'b1;
          pending = 1'b1;
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        pending = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_unexpected_output: got res=%h dest=%0d required no output", result, destReg);
        end else begin
          e = exp_q.pop_front();
          g.res = result; g.we = write_enable; g.dest = destReg;
          g.sd = store_data; g.sda = storeDataAdrOut;
          g.dmwe = data_memory_write_enable; g.fz = flag_z; g.fc = flag_c;
          g.chk_res = e.chk_res; g.chk_dest = e.chk_dest; g.chk_sd = e.chk_sd;
          if (!e.chk_res)  begin g.res = '0;  e.res = '0;  end
          if (!e.chk_dest) begin g.dest = '0; e.dest = '0; end
          if (!e.chk_sd)   begin g.sd = '0;   e.sd = '0;   end
          if (g !== e) begin
            n_bad++;
            $display("FAIL rand_output cyc%0d: got res=%h we=%0b dest=%0d sd=%h sda=%0d dmwe=%0b z=%0b c=%0b required res=%h we=%0b dest=%0d sd=%h sda=%0d dmwe=%0b z=%0b c=%0b",
                     cyc, g.res, g.we, g.dest, g.sd, g.sda, g.dmwe, g.fz, g.fc,
                     e.res, e.we, e.dest, e.sd, e.sda, e.dmwe, e.fz, e.fc);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(opcode), int'(opAAdr), int'(opBAdr), int'(dest_reg),
                              int'(storeDataAdr), int'(operandA), int'(operandB)));
        pending = 1'b0;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: got %0d outstanding results required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; opAAdr = '0; opBAdr = '0; dest_reg = '0;
    storeDataAdr = '0; operandA = '0; operandB = '0;
    test_reset();
    test_alu_basics();
    test_mul_latency();
    test_forwarding();
    test_store_backpressure();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
